// File: rtl/panel_mem_sequencer.sv
// Front-panel EXAMINE/DEPOSIT sequencer: debounces the buttons, takes the bus via hold_req/hold_ack, runs one memory access.
// Optional REQ timeout with a sticky error flag is enabled by defining PANEL_HOLD_TIMEOUT_EN.
module panel_mem_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned HOLD_TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        examine_pb,
    input  logic        examine_next_pb,
    input  logic        deposit_pb,
    input  logic        deposit_next_pb,
    input  logic [15:0] sw_in,
    output logic        hold_req,
    input  logic        hold_ack,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] panel_addr,
    output logic [7:0]  panel_data,
    output logic        busy,
    output logic        error
);
    localparam int unsigned NB = 4;
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    if (DEBOUNCE_CYCLES == 0 || HOLD_TIMEOUT == 0) begin : g_bad_cfg
        $error("panel_mem_sequencer: DEBOUNCE_CYCLES and HOLD_TIMEOUT must be nonzero");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WRITE   = 3'd2,
        READ    = 3'd3,
        CAPTURE = 3'd4,
        RELEASE = 3'd5
    } state_t;

    logic [NB-1:0] btn;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [CW-1:0] cnt [NB];

    state_t        state;
    logic          is_dep;
    logic [15:0]   addr;
    logic [7:0]    wdata;

    // Bit order doubles as acceptance priority: lowest index wins.
    assign btn = {deposit_next_pb, deposit_pb, examine_next_pb, examine_pb};

    // Synchronize, then flip the debounced level after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
            for (int i = 0; i < NB; i++) cnt[i] <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= '0;
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt[i]   <= '0;
                    level[i] <= sync2[i];
                    press[i] <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

`ifdef PANEL_HOLD_TIMEOUT_EN
    localparam int unsigned TW = $clog2(HOLD_TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    logic          err_q;
    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    assign mem_addr   = addr;
    assign mem_wdata  = wdata;
    assign panel_addr = addr;

    // Command FSM; hold_req, mem_we and busy change only on the transitions that affect them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            is_dep     <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            panel_data <= '0;
            hold_req   <= 1'b0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
`ifdef PANEL_HOLD_TIMEOUT_EN
            tcnt       <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|press) begin
                        state    <= REQ;
                        hold_req <= 1'b1;
                        busy     <= 1'b1;
`ifdef PANEL_HOLD_TIMEOUT_EN
                        tcnt     <= '0;
`endif
                        if (press[0]) begin
                            addr   <= sw_in;
                            is_dep <= 1'b0;
`ifdef PANEL_HOLD_TIMEOUT_EN
                            err_q  <= 1'b0;
`endif
                        end else if (press[1]) begin
                            addr   <= addr + 16'd1;
                            is_dep <= 1'b0;
                        end else if (press[2]) begin
                            is_dep <= 1'b1;
                            wdata  <= sw_in[7:0];
                        end else begin
                            addr   <= addr + 16'd1;
                            is_dep <= 1'b1;
                            wdata  <= sw_in[7:0];
                        end
                    end
                end
                REQ: begin
                    if (hold_ack) begin
                        if (is_dep) begin
                            state  <= WRITE;
                            mem_we <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
`ifdef PANEL_HOLD_TIMEOUT_EN
                    else if (tcnt == TW'(HOLD_TIMEOUT - 1)) begin
                        state    <= RELEASE;
                        hold_req <= 1'b0;
                        err_q    <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
`endif
                end
                WRITE: begin
                    mem_we <= 1'b0;
                    state  <= READ;
                end
                READ: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    panel_data <= mem_rdata;
                    hold_req   <= 1'b0;
                    state      <= RELEASE;
                end
                RELEASE: begin
                    if (!hold_ack) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    hold_req <= 1'b0;
                    mem_we   <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_panel_mem_sequencer.sv
// Directed bench for panel_mem_sequencer: vector table plus bounce, reset and hold-timeout sequences.
module tb_panel_mem_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  pb;
    logic [15:0] sw_in;
    logic        hold_req;
    logic        hold_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic [15:0] panel_addr;
    logic [7:0]  panel_data;
    logic        busy;
    logic        error;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  ram [65536];
    logic [1:0]  ack_sh = '0;
    logic [1:0]  ack_mode;      // 0: ack = hold_req delayed 2, 1: stuck 0, 2: stuck 1
    int          txn_cnt = 0;
    int          wr_cnt  = 0;
    logic [15:0] last_waddr = '0;
    logic [7:0]  last_wdata = '0;
    logic        prev_busy  = 1'b0;

    panel_mem_sequencer #(.DEBOUNCE_CYCLES(4), .HOLD_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .examine_pb(pb[0]), .examine_next_pb(pb[1]),
        .deposit_pb(pb[2]), .deposit_next_pb(pb[3]),
        .sw_in(sw_in), .hold_req(hold_req), .hold_ack(hold_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .panel_addr(panel_addr), .panel_data(panel_data),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ack_sh <= {ack_sh[0], hold_req};
    assign hold_ack = (ack_mode == 2'd0) ? ack_sh[1] : (ack_mode == 2'd2);

    // Synchronous RAM, read data one cycle after the address.
    always @(posedge clk) begin
        logic [7:0] rd;
        rd = ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_wdata;
        mem_rdata <= rd;
    end

    always @(negedge clk) begin
        if (busy && !prev_busy) txn_cnt++;
        prev_busy = busy;
        if (mem_we) begin
            wr_cnt++;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic press_btn(input logic [3:0] m, input logic [15:0] sw);
        @(posedge clk); #1;
        sw_in = sw;
        pb    = m;
        repeat (10) @(posedge clk);
        #1 pb = '0;
        repeat (40) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  btn;
        logic [15:0] sw;
        logic [15:0] exp_addr;
        logic [7:0]  exp_data;
        int          exp_writes;
        logic [7:0]  exp_wdata;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int t0;
        int w0;
        int n;
        logic seen;

        vecs[0] = '{4'b0001, 16'h1234, 16'h1234, 8'hA5, 0, 8'h00};
        vecs[1] = '{4'b0001, 16'h0010, 16'h0010, 8'h11, 0, 8'h00};
        vecs[2] = '{4'b0100, 16'hAB3C, 16'h0010, 8'h3C, 1, 8'h3C};
        vecs[3] = '{4'b1000, 16'h0077, 16'h0011, 8'h77, 1, 8'h77};
        vecs[4] = '{4'b0010, 16'h5555, 16'h0012, 8'h22, 0, 8'h00};
        vecs[5] = '{4'b0001, 16'hFFFF, 16'hFFFF, 8'h5A, 0, 8'h00};
        vecs[6] = '{4'b1010, 16'h0099, 16'h0000, 8'hC3, 0, 8'h00};

        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h1234] = 8'hA5;
        ram[16'h0010] = 8'h11;
        ram[16'h0012] = 8'h22;
        ram[16'hFFFF] = 8'h5A;
        ram[16'h0000] = 8'hC3;
        ram[16'h4321] = 8'h9E;

        reset    = 1'b1;
        pb       = '0;
        sw_in    = '0;
        ack_mode = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_req", 32'(hold_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_panel_addr", 32'(panel_addr), 32'd0);
        chk("rst_panel_data", 32'(panel_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            t0 = txn_cnt;
            w0 = wr_cnt;
            press_btn(vecs[i].btn, vecs[i].sw);
            chk($sformatf("v%0d_panel_addr", i), 32'(panel_addr), 32'(vecs[i].exp_addr));
            chk($sformatf("v%0d_panel_data", i), 32'(panel_data), 32'(vecs[i].exp_data));
            chk($sformatf("v%0d_txns", i), 32'(txn_cnt - t0), 32'd1);
            chk($sformatf("v%0d_writes", i), 32'(wr_cnt - w0), 32'(vecs[i].exp_writes));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
            chk($sformatf("v%0d_hold_req", i), 32'(hold_req), 32'd0);
            if (vecs[i].exp_writes > 0) begin
                chk($sformatf("v%0d_waddr", i), 32'(last_waddr), 32'(vecs[i].exp_addr));
                chk($sformatf("v%0d_wdata", i), 32'(last_wdata), 32'(vecs[i].exp_wdata));
            end
        end

        // Bouncing contact: 2-cycle segments never satisfy the 4-cycle stability window.
        t0 = txn_cnt;
        @(posedge clk); #1;
        sw_in = 16'h1234;
        for (int k = 0; k < 10; k++) begin
            pb[0] = ~pb[0];
            repeat (2) @(posedge clk);
            #1;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("bounce_no_early", 32'(txn_cnt - t0), 32'd0);
        pb[0] = 1'b1;
        repeat (15) @(posedge clk);
        #1 pb[0] = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("bounce_txns", 32'(txn_cnt - t0), 32'd1);
        chk("bounce_panel_data", 32'(panel_data), 32'hA5);

        // Reset while stalled in REQ with hold_ack rising, button held through reset.
        ack_mode = 2'd1;
        sw_in    = 16'h4321;
        pb[0]    = 1'b1;
        seen     = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = hold_req;
        end
        chk("rstmid_req_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        ack_mode = 2'd2;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        ack_mode = 2'd0;
        t0 = txn_cnt;
        chk("rstmid_hold_req", 32'(hold_req), 32'd0);
        chk("rstmid_mem_we", 32'(mem_we), 32'd0);
        chk("rstmid_panel_addr", 32'(panel_addr), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("held_no_early", 32'(busy), 32'd0);
        repeat (20) @(posedge clk);
        #1 pb[0] = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("held_txns", 32'(txn_cnt - t0), 32'd1);
        chk("held_panel_addr", 32'(panel_addr), 32'h4321);
        chk("held_panel_data", 32'(panel_data), 32'h9E);

`ifdef PANEL_HOLD_TIMEOUT_EN
        // hold_ack never arrives: REQ gives up after 8 cycles without touching memory.
        ack_mode = 2'd1;
        t0 = txn_cnt;
        w0 = wr_cnt;
        @(posedge clk); #1;
        sw_in = 16'h1234;
        pb[0] = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = hold_req;
        end
        chk("to_req_seen", 32'(seen), 32'd1);
        n = 1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!hold_req) break;
            n++;
        end
        chk("to_req_cycles", 32'(n), 32'd8);
        #1 pb[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("to_error", 32'(error), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_hold_req", 32'(hold_req), 32'd0);
        chk("to_writes", 32'(wr_cnt - w0), 32'd0);
        chk("to_txns", 32'(txn_cnt - t0), 32'd1);
        chk("to_panel_data", 32'(panel_data), 32'h9E);
        ack_mode = 2'd0;
        press_btn(4'b0001, 16'h0010);
        chk("to_clear_error", 32'(error), 32'd0);
        chk("to_clear_data", 32'(panel_data), 32'h3C);
`else
        chk("no_timeout_error", 32'(error), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/panel_mem_sequencer.md
Name: panel_mem_sequencer

Overview:
- Front-panel command sequencer between the debounced EXAMINE/EXAMINE NEXT/DEPOSIT/DEPOSIT NEXT push buttons and the machine's memory bus.
- Converts each press into exactly one memory transaction. It first obtains the bus from the CPU through a hold request/acknowledge handshake, then performs the access and returns the bus.
- Holds the panel address and data registers that drive the address/data LEDs while the machine is paused.

Parameters:
- DEBOUNCE_CYCLES, 250000, cycles a button input must be stable before its level is accepted (10 ms at 25 MHz).
- HOLD_TIMEOUT, 1024, cycles to wait for hold_ack before aborting (used only with the optional feature).

Ports:
- clk  in  1  system clock (pixel/CPU clock domain).
- reset  in  1  synchronous, active-high reset.
- examine_pb  in  1  EXAMINE button, active-high, asynchronous to clk.
- examine_next_pb  in  1  EXAMINE NEXT button, active-high, asynchronous.
- deposit_pb  in  1  DEPOSIT button, active-high, asynchronous.
- deposit_next_pb  in  1  DEPOSIT NEXT button, active-high, asynchronous.
- sw_in  in  16  panel switch word: full address for EXAMINE; bits [7:0] are the data for DEPOSIT.
- hold_req  out  1  request for the CPU to release the bus.
- hold_ack  in  1  CPU has released the bus.
- mem_addr  out  16  memory address.
- mem_wdata  out  8  memory write data.
- mem_we  out  1  single-cycle write strobe.
- mem_rdata  in  8  memory read data; synchronous RAM, valid 1 cycle after the address.
- panel_addr  out  16  address register shown on the LEDs.
- panel_data  out  8  data register shown on the LEDs.
- busy  out  1  high whenever the state is not IDLE.
- error  out  1  sticky timeout flag (optional feature only; tied 0 otherwise).

Behaviour:
- Input conditioning: each button passes through a 2-flop synchronizer, then a per-button counter. The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles. A press event is a one-cycle pulse on the rising edge of the debounced level. Releases generate nothing.
- Command selection: only press events arriving in IDLE are accepted. Events arriving while busy are discarded, not queued. On simultaneous events, priority is EXAMINE > EXAMINE NEXT > DEPOSIT > DEPOSIT NEXT, and the losers are discarded.
- Address update, latched on acceptance:
  - EXAMINE: addr <= sw_in.
  - EXAMINE NEXT and DEPOSIT NEXT: addr <= addr+1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
  - DEPOSIT: addr unchanged.
  - wdata <= sw_in[7:0] for both deposits.
- FSM states: IDLE, REQ, WRITE, READ, CAPTURE, RELEASE.
  - IDLE -> REQ on an accepted command; hold_req goes high on the next cycle.
  - REQ: hold_req=1. Wait for hold_ack=1, then go to WRITE for a deposit or READ for an examine.
  - WRITE: one cycle with mem_addr=addr, mem_wdata=wdata, mem_we=1, then READ (read-back).
  - READ: mem_addr=addr, mem_we=0, one cycle.
  - CAPTURE: panel_data <= mem_rdata, then RELEASE.
  - RELEASE: hold_req=0. Wait for hold_ack=0, then IDLE.
- Latency with hold_ack already high: examine takes 4 cycles from acceptance to the panel_data update; deposit takes 5.
- panel_addr updates on acceptance, mirroring addr.
- mem_addr outputs addr in every state. mem_we is high only in WRITE.
- Reset (any state, including mid-transaction): the next edge gives state=IDLE, hold_req=0, mem_we=0, addr=0, wdata=0, panel_addr=0, panel_data=0, error=0, debounced levels=0, debounce counters=0.
- hold_ack dropping during WRITE/READ/CAPTURE is a protocol violation. The sequence still completes; no recovery is required.

Optional Feature:
- Macro PANEL_HOLD_TIMEOUT_EN.
- When defined: a counter runs in REQ. If hold_ack is not seen within HOLD_TIMEOUT cycles, the FSM goes to RELEASE without any memory access, error is set sticky, and panel_data is unchanged. error is cleared only by reset or by the next successful acceptance of EXAMINE.
- When undefined: REQ waits indefinitely, the counter is not synthesized, and error is constant 0.

Test Plan:
- DEBOUNCE_CYCLES=4, hold_ack tied to hold_req delayed 2 cycles, RAM[16'h1234]=8'hA5. Set sw_in=16'h1234 and pulse examine_pb for 10 cycles -> exactly one transaction, panel_addr=16'h1234, panel_data=8'hA5, mem_we never high, busy returns to 0.
- Bounce: toggle examine_pb every 2 cycles for 20 cycles, then hold high -> exactly one examine, with none started before the stable period.
- Deposit: addr=16'h0010, sw_in[7:0]=8'h3C, press deposit_pb -> one mem_we pulse at 16'h0010 with 8'h3C, panel_data=8'h3C. Then press deposit_next with sw_in[7:0]=8'h77 -> write at 16'h0011, panel_addr=16'h0011.
- Wrap and priority: examine 16'hFFFF, then press examine_next and deposit_next in the same cycle -> only examine_next runs, panel_addr=16'h0000.
- Reset in the REQ/READ state with hold_ack high -> hold_req=0, mem_we=0, panel_addr=0 after one edge. A button held through reset produces one press after the debounce period.
- With PANEL_HOLD_TIMEOUT_EN defined, HOLD_TIMEOUT=8, hold_ack stuck 0: press examine -> hold_req high for 8 cycles, then low, error=1, busy=0, no mem access. A later examine with working hold_ack clears error.
